fft_pingpong_buffer: RTL and testbench
======================================

// Module: fft_pingpong_buffer
// PURPOSE
//  Parametrised ping-pong sample buffer feeding the 64-point FFT core; successor to the snapshot register bank.
//  Streams one frame of DEPTH samples in through a valid/ready port while the other bank is read out.
//  Readout is in natural or bit-reversed order, selectable per frame.
//  Sits between the ADC sample stream and the FFT butterfly stage, decoupling the two rates.
// PARAMETERS
//  WIDTH  12  sample width in bits
//  DEPTH  64  samples per frame; power of two, >= 2; AW = log2(DEPTH) derived as localparam
// PORTS
//  clk         in   1      single clock; all logic on rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  flush       in   1      synchronous clear of counters/flags (memory contents kept)
//  bitrev_en   in   1      1 = bit-reversed readout for frame being completed
//  in_valid    in   1      in_data valid
//  in_ready    out  1      buffer can accept a sample
//  in_data     in   WIDTH  input sample
//  out_valid   out  1      out_data valid
//  out_ready   in   1      consumer accepts out_data
//  out_data    out  WIDTH  output sample
//  out_index   out  AW     position within output frame (0..DEPTH-1, always natural count)
//  out_last    out  1      high with final sample of a frame
//  frames_out  out  16     count of fully read frames, wraps at 2^16
// BEHAVIOUR
//  - Storage: two banks, mem[2][DEPTH] x WIDTH, flip-flops; per-bank full[b] and mode[b] flags.
//  - Reset (rst_n=0, async): wr_bank=rd_bank=0, wr_cnt=rd_cnt=0, full=2'b00, mode=2'b00, frames_out=0.
//    Outputs then: in_ready=1, out_valid=0, out_data=0, out_index=0, out_last=0, frames_out=0. Memory not cleared.
//  - Write: in_ready = ~full[wr_bank] (registered flags only; no path from out_ready to in_ready).
//    On in_valid&in_ready: mem[wr_bank][wr_cnt] <= in_data; wr_cnt++.
//    When wr_cnt==DEPTH-1 accepted: wr_cnt->0, full[wr_bank]<=1, mode[wr_bank]<=bitrev_en, wr_bank toggles.
//  - Read: out_valid = full[rd_bank]; rises the cycle after the last sample of a frame is written.
//    Read address = mode[rd_bank] ? bitrev_AW(rd_cnt) : rd_cnt; out_data combinational from mem, forced 0 when !out_valid.
//    out_index = rd_cnt; out_last = out_valid & (rd_cnt==DEPTH-1).
//    On out_valid&out_ready: rd_cnt++. On last: rd_cnt->0, full[rd_bank]<=0, rd_bank toggles, frames_out++.
//  - Data held stable while out_valid&!out_ready (AXI-style; no drop, no reorder).
//  - Both banks full: in_ready=0; in_valid samples not accepted (producer must hold). in_ready returns cycle after frame release.
//  - Same cycle: last write to bank X and last read releasing bank Y (X!=Y) both take effect; flags update independently.
//  - Same bank cannot be simultaneously written and read (guaranteed by full flags); no bypass.
//  - flush=1 (sync, priority over handshakes): same state as reset except memory; in-flight partial frames discarded.
//  - Reset/flush mid-frame: partial input frame lost; next accepted sample goes to bank 0 index 0.
//  - Throughput: one sample in and one out per cycle sustained; latency last-in -> first-out = 1 cycle.
// TESTING
//  1. Reset, no stimulus -> in_ready=1, out_valid=0, out_data=0, frames_out=0.
//  2. bitrev_en=0, write 0..63 back-to-back, out_ready=1 -> out_valid 1 cycle after 64th write; out_data 0..63, out_last on 63, frames_out=1.
//  3. bitrev_en=1, write data=k at k=0..63 -> out_data 0,32,16,48,8,40,... (bitrev6), out_index 0..63.
//  4. out_ready=0, write 130 samples -> in_ready=0 after 128th accept; 129th held; read 64 -> in_ready=1 next cycle, no loss.
//  5. Continuous in/out, frame N last write coincides with frame N-1 last read -> no stall, no in_ready glitch, order intact.
//  6. 10 samples written then flush=1 (repeat with rst_n pulse) -> out_valid=0; next 64 samples read back exactly as written.

Source files
------------

// File: rtl/fft_pingpong_buffer.sv
// Two-bank ping-pong frame buffer: one bank fills from the sample stream while the other drains,
// in natural or bit-reversed order chosen when the frame completes.
module fft_pingpong_buffer #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             bitrev_en_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [AW-1:0]    out_index_o,
    output logic             out_last_o,
    output logic [15:0]      frames_out_o
);

    logic [WIDTH-1:0] mem_q [2][DEPTH];

    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic [1:0]    full_q, full_d;
    logic [1:0]    mode_q, mode_d;
    logic [15:0]   frames_q, frames_d;

    logic          wr_fire, rd_fire, wr_end, rd_end;
    logic [AW-1:0] rd_addr;

    function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    // in_ready depends on registered flags only, never on out_ready.
    assign in_ready_o   = ~full_q[wr_bank_q];
    assign out_valid_o  = full_q[rd_bank_q];
    assign wr_fire      = in_valid_i & in_ready_o;
    assign rd_fire      = out_valid_o & out_ready_i;
    assign wr_end       = (wr_cnt_q == AW'(DEPTH - 1));
    assign rd_end       = (rd_cnt_q == AW'(DEPTH - 1));
    assign rd_addr      = mode_q[rd_bank_q] ? bit_rev(rd_cnt_q) : rd_cnt_q;
    assign out_data_o   = out_valid_o ? mem_q[rd_bank_q][rd_addr] : '0;
    assign out_index_o  = rd_cnt_q;
    assign out_last_o   = out_valid_o & rd_end;
    assign frames_out_o = frames_q;

    // The write bank is never full and the read bank always is, so both updates may coexist.
    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        full_d    = full_q;
        mode_d    = mode_q;
        frames_d  = frames_q;
        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_end) begin
                wr_cnt_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                mode_d[wr_bank_q] = bitrev_en_i;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        if (rd_fire) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (rd_end) begin
                rd_cnt_d          = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
                frames_d          = frames_q + 16'd1;
            end
        end
        if (flush_i) begin
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            wr_cnt_d  = '0;
            rd_cnt_d  = '0;
            full_d    = 2'b00;
            mode_d    = 2'b00;
            frames_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            full_q    <= 2'b00;
            mode_q    <= 2'b00;
            frames_q  <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            full_q    <= full_d;
            mode_q    <= mode_d;
            frames_q  <= frames_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire && !flush_i) begin
            mem_q[wr_bank_q][wr_cnt_q] <= in_data_i;
        end
    end

endmodule

// File: tb/tb_fft_pingpong_buffer.sv
// Directed bench for fft_pingpong_buffer: natural/bit-reversed frames, back-pressure,
// overlapped streaming, flush and mid-frame reset.
module tb_fft_pingpong_buffer;

    localparam int WIDTH = 12;
    localparam int DEPTH = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             bitrev_en;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [5:0]       out_index;
    logic             out_last;
    logic [15:0]      frames_out;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    fft_pingpong_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .bitrev_en_i (bitrev_en),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_index_o (out_index),
        .out_last_o  (out_last),
        .frames_out_o(frames_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int br6(input int k);
        int r;
        r = 0;
        for (int i = 0; i < 6; i++) r[5-i] = k[i];
        return r;
    endfunction

    task automatic write_frame(input int base, input logic br);
        for (int k = 0; k < DEPTH; k++) begin
            in_valid = 1'b1; in_data = WIDTH'(base + k); bitrev_en = br;
            #1;
            chk("wr_ready", in_ready, 1);
            cyc();
        end
        in_valid = 1'b0;
    endtask

    task automatic read_frame(input int base);
        for (int k = 0; k < DEPTH; k++) begin
            out_ready = 1'b1;
            #1;
            chk("rd_valid", out_valid, 1);
            chk("rd_data", out_data, base + k);
            chk("rd_last", out_last, (k == DEPTH - 1) ? 1 : 0);
            cyc();
        end
    endtask

    int exp_br [6] = '{0, 32, 16, 48, 8, 40};

    initial begin
        rst_n = 1'b1; flush = 1'b0; bitrev_en = 1'b0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #3;
        // 1: reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frames", frames_out, 0);
        #7 rst_n = 1'b1;
        cyc();

        // 2: natural order, out_valid must appear one cycle after 64th write
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            in_valid = 1'b1; in_data = WIDTH'(k);
            #1;
            chk("t2_ready", in_ready, 1);
            chk("t2_no_valid", out_valid, 0);
            cyc();
        end
        in_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            chk("t2_valid", out_valid, 1);
            chk("t2_data", out_data, k);
            chk("t2_index", out_index, k);
            chk("t2_last", out_last, (k == 63) ? 1 : 0);
            cyc();
        end
        #1;
        chk("t2_frames", frames_out, 1);
        chk("t2_idle", out_valid, 0);
        cyc();

        // 3: bit-reversed readout
        write_frame(0, 1'b1);
        bitrev_en = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            if (k < 6) chk("t3_br_table", out_data, exp_br[k]);
            chk("t3_data", out_data, br6(k));
            chk("t3_index", out_index, k);
            chk("t3_last", out_last, (k == 63) ? 1 : 0);
            cyc();
        end
        #1;
        chk("t3_frames", frames_out, 2);
        cyc();

        // 4: back-pressure, 128 accepted then producer holds sample 128
        out_ready = 1'b0;
        for (int k = 0; k < 128; k++) begin
            in_valid = 1'b1; in_data = WIDTH'(100 + k);
            #1;
            chk("t4_ready", in_ready, 1);
            cyc();
        end
        in_data = WIDTH'(228);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_full", in_ready, 0);
            chk("t4_hold_data", out_data, 100);
            chk("t4_hold_index", out_index, 0);
            cyc();
        end
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            chk("t4_a_data", out_data, 100 + k);
            chk("t4_a_blocked", in_ready, 0);
            cyc();
        end
        for (int k = 0; k < DEPTH; k++) begin
            in_valid = (k < 2); in_data = WIDTH'(228 + k);
            #1;
            if (k < 2) chk("t4_reopen", in_ready, 1);
            chk("t4_b_data", out_data, 164 + k);
            cyc();
        end
        in_valid = 1'b0;
        #1;
        chk("t4_frames", frames_out, 4);
        chk("t4_drained", out_valid, 0);
        cyc();

        // 5: finish frame C, then overlap writes of D/E with reads of C/D
        for (int k = 2; k < DEPTH; k++) begin
            in_valid = 1'b1; in_data = WIDTH'(228 + k);
            #1;
            chk("t5_c_ready", in_ready, 1);
            cyc();
        end
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < DEPTH; k++) begin
                in_valid = 1'b1; in_data = WIDTH'(400 + 100 * f + k);
                #1;
                chk("t5_ready", in_ready, 1);
                chk("t5_valid", out_valid, 1);
                chk("t5_data", out_data, (f == 0 ? 228 : 400) + k);
                chk("t5_last", out_last, (k == 63) ? 1 : 0);
                cyc();
            end
        end
        in_valid = 1'b0;
        read_frame(500);
        #1;
        chk("t5_frames", frames_out, 7);
        cyc();

        // 6a: partial frame discarded by flush
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_data = WIDTH'(700 + k);
            cyc();
        end
        in_valid = 1'b0; flush = 1'b1;
        cyc();
        flush = 1'b0;
        #1;
        chk("t6_flush_valid", out_valid, 0);
        chk("t6_flush_ready", in_ready, 1);
        chk("t6_flush_frames", frames_out, 0);
        chk("t6_flush_index", out_index, 0);
        cyc();
        write_frame(800, 1'b0);
        read_frame(800);
        #1;
        chk("t6_flush_after", frames_out, 1);
        cyc();

        // 6b: partial frame discarded by asynchronous reset
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_data = WIDTH'(900 + k);
            cyc();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_frames", frames_out, 0);
        chk("t6_rst_ready", in_ready, 1);
        #5 rst_n = 1'b1;
        cyc();
        write_frame(1000, 1'b0);
        read_frame(1000);
        #1;
        chk("t6_rst_after", frames_out, 1);
        chk("t6_rst_idle", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
